// File: rtl/uart_xcvr.sv
// uart_xcvr: 8N1 UART transceiver with internal TX-to-RX loopback for BIST
module uart_xcvr #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       ClK,
  input  logic       Clear_n,
  input  logic       Transmit_Start,
  input  logic [7:0] Tx_Data,
  input  logic       BIST_Mode,
  input  logic       Serial_In,
  output logic       Serial_Out,
  output logic       Tx_Busy,
  output logic [7:0] Rx_Data,
  output logic       Data_Rdy,
  output logic       Framing_Error
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  tx_state_t tx_st;
  rx_state_t rx_st;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [2:0] tx_idx, rx_idx;
  logic [7:0] tx_sh, rx_sh;
  logic tx_line, tx_line_n, tx_last, rx_last, rx_half, rx_sel, s1, s2;
  always_comb begin
    tx_last = tx_cnt == CW'(CLKS_PER_BIT - 1);
    rx_last = rx_cnt == CW'(CLKS_PER_BIT - 1);
    rx_half = rx_cnt == CW'(CLKS_PER_BIT / 2 - 1);
    rx_sel = BIST_Mode ? tx_line : Serial_In;
    tx_line_n = (tx_st == TX_IDLE) ? !Transmit_Start :
                !tx_last ? tx_line :
                (tx_st == TX_START) ? tx_sh[0] :
                (tx_st == TX_DATA && tx_idx != 3'd7) ? tx_sh[1] : 1'b1;
  end
  always_ff @(posedge ClK) begin
    if (!Clear_n) begin
      tx_st <= TX_IDLE;
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_sh <= '0;
      tx_line <= 1'b1;
      Serial_Out <= 1'b1;
      Tx_Busy <= 1'b0;
    end else begin
      tx_line <= tx_line_n;
      Serial_Out <= tx_line_n | BIST_Mode;
      tx_cnt <= (tx_st == TX_IDLE || tx_last) ? '0 : tx_cnt + CW'(1);
      case (tx_st)
        TX_IDLE: if (Transmit_Start) begin
          tx_st <= TX_START;
          tx_sh <= Tx_Data;
          Tx_Busy <= 1'b1;
        end
        TX_START: if (tx_last) begin
          tx_st <= TX_DATA;
          tx_idx <= '0;
        end
        TX_DATA: if (tx_last) begin
          tx_sh <= tx_sh >> 1;
          tx_idx <= tx_idx + 3'd1;
          if (tx_idx == 3'd7) tx_st <= TX_STOP;
        end
        TX_STOP: if (tx_last) begin
          tx_st <= TX_IDLE;
          Tx_Busy <= 1'b0;
        end
        default: tx_st <= TX_IDLE;
      endcase
    end
  end
  always_ff @(posedge ClK) begin
    if (!Clear_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      rx_st <= RX_IDLE;
      rx_cnt <= '0;
      rx_idx <= '0;
      rx_sh <= '0;
      Rx_Data <= '0;
      Data_Rdy <= 1'b0;
      Framing_Error <= 1'b0;
    end else begin
      s1 <= rx_sel;
      s2 <= s1;
      Data_Rdy <= 1'b0;
      Framing_Error <= 1'b0;
      case (rx_st)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (!s2) rx_st <= RX_START;
        end
        RX_START: begin
          rx_cnt <= rx_half ? '0 : rx_cnt + CW'(1);
          rx_idx <= '0;
          if (rx_half) rx_st <= s2 ? RX_IDLE : RX_DATA;
        end
        RX_DATA: begin
          rx_cnt <= rx_last ? '0 : rx_cnt + CW'(1);
          if (rx_last) begin
            rx_sh <= {s2, rx_sh[7:1]};
            rx_idx <= rx_idx + 3'd1;
            if (rx_idx == 3'd7) rx_st <= RX_STOP;
          end
        end
        RX_STOP: begin
          rx_cnt <= rx_last ? '0 : rx_cnt + CW'(1);
          if (rx_last) begin
            rx_st <= s2 ? RX_IDLE : RX_BREAK;
            Data_Rdy <= s2;
            Framing_Error <= !s2;
            if (s2) Rx_Data <= rx_sh;
          end
        end
        RX_BREAK: begin
          rx_cnt <= '0;
          if (s2) rx_st <= RX_IDLE;
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_xcvr.md
Name: uart_xcvr

Overview:
- UART transceiver that sits at the other end of the BIST FSM's interface.
- It consumes Transmit_Start and Tx_Data, serializes the byte onto Serial_Out, deserializes the receive line, and returns Rx_Data with a Data_Rdy pulse.
- BIST_Mode routes the transmit line internally into the receiver, giving a self-contained loopback for built-in self test.
- Frame format: 8N1, LSB first.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per bit (N). Must be even and at least 4. Counter width is clog2(N).

Ports:
- ClK  input  1  clock, all logic on the rising edge
- Clear_n  input  1  synchronous, active-low reset
- Transmit_Start  input  1  level request to send Tx_Data; sampled only while TX is idle
- Tx_Data  input  8  byte to transmit; latched on acceptance
- BIST_Mode  input  1  1 = internal loopback (RX fed from the TX line); 0 = RX fed from Serial_In
- Serial_In  input  1  external asynchronous receive line, idles high
- Serial_Out  output  1  external transmit line (registered)
- Tx_Busy  output  1  high while a frame is in flight
- Rx_Data  output  8  last correctly received byte (registered, held)
- Data_Rdy  output  1  one-cycle pulse when Rx_Data updates
- Framing_Error  output  1  one-cycle pulse when the stop bit is sampled low

Behaviour:
- Reset (Clear_n=0 at a rising edge):
  - Serial_Out=1, Tx_Busy=0, Rx_Data=8'h00, Data_Rdy=0, Framing_Error=0.
  - Both FSMs go to idle; synchronizer flops set to 1.
  - Reset mid-frame aborts both frames immediately. No Data_Rdy or Framing_Error for the aborted frame.
- TX FSM states: TX_IDLE, TX_START, TX_DATA, TX_STOP.
  - TX_IDLE: the cycle Transmit_Start=1 is the acceptance cycle. Tx_Data is latched and the FSM goes to TX_START.
  - Tx_Busy=1 and Serial_Out=0 from the next cycle.
  - TX_START, each of 8 data bits (bit 0 first), and TX_STOP (Serial_Out=1) each last exactly N cycles.
  - After TX_STOP the FSM returns to TX_IDLE and Tx_Busy=0 for at least one cycle.
  - Transmit_Start still high in that cycle starts a new frame. Held-high start therefore gives back-to-back frames with a period of 10N+1 cycles.
  - Tx_Data changes after acceptance have no effect on the current frame.
- Line routing:
  - In BIST_Mode, the internal TX line feeds the RX path and Serial_Out is forced to 1.
  - In that case the external pin stays idle; the internal TX line still toggles.
  - With BIST_Mode=0, Serial_In feeds the RX path.
  - The selected line passes through a 2-flop synchronizer, so loopback latency equals external latency.
- RX FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK.
  - RX_IDLE: a synchronized 0 moves the FSM to RX_START and clears the counter.
  - RX_START: sample at N/2 cycles after the falling edge was detected.
    - Sample 0: go to RX_DATA.
    - Sample 1: glitch; return to RX_IDLE with no outputs.
  - RX_DATA: sample every N cycles from the start midpoint. 8 samples shift in, LSB first.
  - RX_STOP: sample N cycles after the bit-7 sample.
    - Sample 1: Rx_Data gets the shift register and Data_Rdy=1 for one cycle; return to RX_IDLE.
    - Sample 0: Framing_Error=1 for one cycle and Rx_Data is unchanged; go to RX_BREAK.
  - RX_BREAK: wait for a synchronized 1, then go to RX_IDLE. A line held low never retriggers.
  - Data_Rdy and Framing_Error are never both high. Each pulse is exactly one cycle.
- Latency (loopback): Data_Rdy is nominally 9.5N+4 cycles after the acceptance cycle, tolerance ±1. For N=16 this is 156±1.
- TX and RX run independently and concurrently.
- Changing BIST_Mode mid-frame may corrupt that frame. Both FSMs must still return to idle within 11N cycles once the line is high; no lockup.

Test Plan:
- Reset: Clear_n=0 for 2 cycles during an active frame, then release -> Serial_Out=1, Tx_Busy=0, Rx_Data=00, no Data_Rdy for 12N cycles.
- Loopback, N=16: BIST_Mode=1, Tx_Data=A5, Transmit_Start pulsed for 1 cycle -> Serial_Out stays 1, Tx_Busy high for exactly 160 cycles, Data_Rdy pulse at 156±1 with Rx_Data=A5.
- Back-to-back loopback: Transmit_Start held high with Tx_Data=3C -> Tx_Busy low exactly 1 cycle between frames, Data_Rdy pulses spaced 161 cycles apart, Rx_Data=3C each time.
- External TX waveform: BIST_Mode=0, send 0x81 -> Serial_Out is 0 for 16 cycles (start), then bits 1,0,0,0,0,0,0,1 at 16 cycles each, then 1 for 16 cycles (stop).
- External RX framing error: drive Serial_In with 0x55 and stop bit 0, line held low 3N more cycles -> one Framing_Error pulse, no Data_Rdy, Rx_Data unchanged. Then a valid 0xC3 frame -> Data_Rdy pulse, Rx_Data=C3.
- Glitch rejection: Serial_In low for N/2-2 cycles, then high -> no Data_Rdy, no Framing_Error, RX back in idle. A following valid frame 0x5A is received correctly.
